// File: rtl/mem_arbiter.sv
// Shares the single ram between instruction fetch and load/store; read hit acks 2 cycles after request.
// Requests hold until a one-cycle ack; per-port stall is req & ~ack; accesses abort after TIMEOUT cycles.
module mem_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_ack_o,
    output logic [31:0] inst_data_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_ack_o,
    output logic [31:0] data_rdata_o,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_hit1_i,
    input  logic        ram_hit2_i
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t        r_state;
    logic          r_grant_data;
    logic          r_last_data;
    logic [TW-1:0] r_tcnt;
    logic          r_inst_ack;
    logic [31:0]   r_inst_data;
    logic          r_data_ack;
    logic [31:0]   r_data_rdata;
    logic          r_err;
    logic          r_busy;
    logic          r_ce;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [3:0]    r_sel;
    logic [31:0]   r_wdata;

    logic          w_grant_data;
    logic          w_done;
    logic          w_timeout;
    logic [31:0]   w_rd_val;

    // On contention the port that did not win last time gets the ram.
    assign w_grant_data = data_req_i & (~inst_req_i | ~r_last_data);
    // Writes must wait for the slow path; hit1 only reflects a read hit.
    assign w_done       = r_we ? ram_hit2_i : (ram_hit1_i | ram_hit2_i);
    assign w_timeout    = (r_tcnt == TW'(TIMEOUT - 1));
    assign w_rd_val     = (w_done && !r_we) ? ram_data_i : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant_data <= 1'b0;
            r_last_data  <= 1'b0;
            r_tcnt       <= '0;
            r_inst_ack   <= 1'b0;
            r_inst_data  <= 32'h0;
            r_data_ack   <= 1'b0;
            r_data_rdata <= 32'h0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_ce         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_sel        <= 4'h0;
            r_wdata      <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inst_req_i || data_req_i) begin
                        r_grant_data <= w_grant_data;
                        r_ce         <= 1'b1;
                        r_we         <= w_grant_data & data_we_i;
                        r_addr       <= w_grant_data ? data_addr_i : inst_addr_i;
                        r_sel        <= w_grant_data ? data_sel_i : 4'b1111;
                        r_wdata      <= w_grant_data ? data_wdata_i : 32'h0;
                        r_busy       <= 1'b1;
                        r_tcnt       <= '0;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    // Completion takes priority over a coincident timeout.
                    if (w_done || w_timeout) begin
                        r_ce    <= 1'b0;
                        r_we    <= 1'b0;
                        r_err   <= ~w_done;
                        r_state <= S_RESP;
                        if (r_grant_data) begin
                            r_data_ack   <= 1'b1;
                            r_data_rdata <= w_rd_val;
                        end else begin
                            r_inst_ack  <= 1'b1;
                            r_inst_data <= w_rd_val;
                        end
                    end
                end
                S_RESP: begin
                    r_inst_ack   <= 1'b0;
                    r_inst_data  <= 32'h0;
                    r_data_ack   <= 1'b0;
                    r_data_rdata <= 32'h0;
                    r_err        <= 1'b0;
                    r_last_data  <= r_grant_data;
                    r_tcnt       <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inst_ack_o   = r_inst_ack;
    assign inst_data_o  = r_inst_data;
    assign data_ack_o   = r_data_ack;
    assign data_rdata_o = r_data_rdata;
    assign err_o        = r_err;
    assign busy_o       = r_busy;
    assign ram_ce_o     = r_ce;
    assign ram_we_o     = r_we;
    assign ram_addr_o   = r_addr;
    assign ram_sel_o    = r_sel;
    assign ram_data_o   = r_wdata;
    assign stall_if_o   = inst_req_i & ~r_inst_ack;
    assign stall_mem_o  = data_req_i & ~r_data_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural ram model and an ack scoreboard.
module tb_mem_arbiter;
    localparam int M_FAST  = 0;
    localparam int M_SLOW  = 1;
    localparam int M_NEVER = 2;
    localparam int M_BOTH  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = 32'h0;
    logic        inst_ack_o;
    logic [31:0] inst_data_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = 32'h0;
    logic [3:0]  data_sel_i = 4'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_ack_o;
    logic [31:0] data_rdata_o;
    logic        stall_if_o, stall_mem_o, err_o, busy_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;
    logic        ram_hit1_i, ram_hit2_i;

    int   total = 0;
    int   bad = 0;
    int   mode = M_FAST;
    int   slow_n = 200;
    int   ce_cnt = 0;
    logic stray = 1'b0;

    typedef struct {
        bit          is_data;
        logic [31:0] dat;
        bit          err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_ack_o(inst_ack_o), .inst_data_o(inst_data_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_sel_i(data_sel_i), .data_wdata_i(data_wdata_i),
        .data_ack_o(data_ack_o), .data_rdata_o(data_rdata_o),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
        .err_o(err_o), .busy_o(busy_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .ram_hit1_i(ram_hit1_i), .ram_hit2_i(ram_hit2_i)
    );

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return (a == 32'h40) ? 32'h3C010001 : (32'hA5000000 | a);
    endfunction

    // Ram model: counts cycles with ce high; restarts whenever ce drops.
    always @(posedge clk) begin
        if (!ram_ce_o) ce_cnt <= 0;
        else           ce_cnt <= ce_cnt + 1;
    end
    assign ram_data_i = ram_rd(ram_addr_o);
    assign ram_hit1_i = ram_ce_o && (mode == M_FAST || mode == M_BOTH || stray);
    assign ram_hit2_i = ram_ce_o && ((mode == M_SLOW && ce_cnt == slow_n - 1) || mode == M_BOTH);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_data, input logic [31:0] dat, input bit err);
        exp_t e;
        e.is_data = is_data;
        e.dat     = dat;
        e.err     = err;
        sb.push_back(e);
    endtask

    task automatic wait_any(input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            seen = inst_ack_o | data_ack_o;
        end
        check("ack_within_budget", 32'(seen), 32'd1);
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (inst_ack_o || data_ack_o)) begin
            check("single_port_ack", 32'(inst_ack_o & data_ack_o), 32'd0);
            check("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", 32'(data_ack_o), 32'(e.is_data));
                check("ack_data", e.is_data ? data_rdata_o : inst_data_o, e.dat);
                check("ack_other_data", e.is_data ? inst_data_o : data_rdata_o, 32'h0);
                check("ack_err", 32'(err_o), 32'(e.err));
                check("ce_low_in_resp", 32'(ram_ce_o), 32'd0);
            end
        end
    end

    initial begin
        int cyc;
        int ce_cycles;
        int bad_attr;
        bit seen;

        // Reset with both ports requesting.
        rst = 1'b1;
        inst_req_i = 1'b1; inst_addr_i = 32'h20;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h100; data_sel_i = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        check("reset_outputs_zero",
              32'(|{inst_ack_o, inst_data_o, data_ack_o, data_rdata_o, err_o, busy_o,
                    ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o}), 32'd0);
        check("reset_stall_if", 32'(stall_if_o), 32'd1);
        check("reset_stall_mem", 32'(stall_mem_o), 32'd1);
        rst = 1'b0;

        // Continuous contention: DATA, INST, DATA, INST.
        push(1, ram_rd(32'h100), 0);
        push(0, ram_rd(32'h20), 0);
        push(1, ram_rd(32'h100), 0);
        push(0, ram_rd(32'h20), 0);
        for (int k = 0; k < 4; k++) begin
            wait_any(20, cyc);
            @(posedge clk); #1;
            check("ce_low_after_resp", 32'(ram_ce_o), 32'd0);
            if (k == 3) begin
                inst_req_i = 1'b0;
                data_req_i = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1 check("idle_not_busy", 32'(busy_o), 32'd0);

        // Instruction read cache hit.
        @(posedge clk); #1;
        mode = M_FAST; inst_req_i = 1'b1; inst_addr_i = 32'h40;
        push(0, 32'h3C010001, 0);
        wait_any(10, cyc);
        check("hit_latency", 32'(cyc - 1), 32'd2);
        check("hit_stall_if_falls", 32'(stall_if_o), 32'd0);
        @(posedge clk); #1;
        inst_req_i = 1'b0;
        check("hit_ack_one_cycle", 32'(inst_ack_o), 32'd0);
        check("hit_data_cleared", inst_data_o, 32'h0);

        // Slow store with a stray hit1 during the wait.
        @(posedge clk); #1;
        mode = M_SLOW; slow_n = 200;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h80;
        data_sel_i = 4'b0011; data_wdata_i = 32'h12345678;
        push(1, 32'h0, 0);
        cyc = 0; seen = 1'b0; ce_cycles = 0; bad_attr = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ram_ce_o) begin
                ce_cycles++;
                if (ram_we_o !== 1'b1 || ram_sel_o !== 4'b0011) bad_attr++;
            end
            stray = (cyc == 50);
            seen  = inst_ack_o | data_ack_o;
        end
        stray = 1'b0;
        check("store_acked", 32'(seen), 32'd1);
        check("store_latency", 32'(cyc), 32'd202);
        check("store_access_cycles", 32'(ce_cycles), 32'd200);
        check("store_we_sel_held", 32'(bad_attr), 32'd0);
        check("store_addr", ram_addr_o, 32'h80);
        check("store_wdata", ram_data_o, 32'h12345678);
        @(posedge clk); #1;
        data_req_i = 1'b0; data_we_i = 1'b0;
        check("store_ack_once", 32'(data_ack_o), 32'd0);

        // hit1 and hit2 together give a single completion.
        @(posedge clk); #1;
        mode = M_BOTH; inst_req_i = 1'b1; inst_addr_i = 32'h44;
        push(0, ram_rd(32'h44), 0);
        wait_any(10, cyc);
        check("both_hits_latency", 32'(cyc - 1), 32'd2);
        @(posedge clk); #1;
        inst_req_i = 1'b0;
        check("both_hits_single_ack", 32'(inst_ack_o), 32'd0);

        // Timeout: ram never completes.
        @(posedge clk); #1;
        mode = M_NEVER; inst_req_i = 1'b1; inst_addr_i = 32'h200;
        push(0, 32'h0, 1);
        wait_any(1100, cyc);
        check("timeout_latency", 32'(cyc), 32'd1025);
        check("timeout_err", 32'(err_o), 32'd1);
        @(posedge clk); #1;
        inst_req_i = 1'b0;
        check("timeout_err_pulse", 32'(err_o), 32'd0);

        // Completion in the same cycle as timeout: completion wins.
        @(posedge clk); #1;
        mode = M_SLOW; slow_n = 1023;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h204; data_sel_i = 4'hF;
        push(1, ram_rd(32'h204), 0);
        wait_any(1100, cyc);
        check("edge_latency", 32'(cyc), 32'd1025);
        check("edge_no_err", 32'(err_o), 32'd0);
        @(posedge clk); #1;
        data_req_i = 1'b0;

        // Reset in the middle of a slow read.
        @(posedge clk); #1;
        mode = M_SLOW; slow_n = 200;
        data_req_i = 1'b1; data_addr_i = 32'h300;
        repeat (51) @(posedge clk);
        #1 check("midreset_in_access", 32'(ram_ce_o), 32'd1);
        rst = 1'b1; data_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_ce_low", 32'(ram_ce_o), 32'd0);
        check("midreset_not_busy", 32'(busy_o), 32'd0);
        check("midreset_no_ack", 32'(data_ack_o | inst_ack_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        mode = M_FAST; data_req_i = 1'b1;
        push(1, ram_rd(32'h300), 0);
        wait_any(10, cyc);
        check("after_reset_latency", 32'(cyc - 1), 32'd2);
        @(posedge clk); #1;
        data_req_i = 1'b0;

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
